list_ctrl: RTL and testbench
============================

LIST_CTRL -- requirements
Module: list_ctrl

Interface
REQ-001 Parameter MAX_LENGTH, default 256, SHALL give the maximum element count of the attached list.
REQ-002 Parameter WIDTH, default 2, SHALL give the element width in bits.
REQ-003 CLK  in  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-004 RST  in  1  SHALL be a synchronous, active-high reset.
REQ-005 wr_req  in  1  SHALL carry the requester's push request; wr_data  in  WIDTH  SHALL carry the element to push.
REQ-006 wr_ack  out  1  SHALL indicate that the push was accepted this cycle.
REQ-007 rd_req  in  1  SHALL request a full readout; rd_busy  out  1  SHALL be high while a readout is in progress.
REQ-008 out_valid  out  1, out_data  out  WIDTH and out_last  out  1 SHALL form the readout beat stream.
REQ-009 done  out  1  SHALL pulse for one cycle at the end of a readout.
REQ-010 count  out  BITS(MAX_LENGTH)+1  SHALL give the stored element count; full  out  1  SHALL be high when count==MAX_LENGTH.
REQ-011 List side: list_push  out  1, list_data_in  out  WIDTH, list_en_read  out  1, list_data_out  in  WIDTH, list_read_done  in  1.

Function
REQ-012 The FSM SHALL have the states IDLE, ARM, STREAM, WAIT_DONE and FIN.
REQ-013 In IDLE, wr_ack SHALL equal wr_req && !full (combinational); list_push SHALL equal wr_ack; list_data_in SHALL equal wr_data; count SHALL increment on each wr_ack.
REQ-014 wr_ack SHALL be 0 in every state other than IDLE, and whenever full=1.
REQ-015 Arbitration: if wr_req and rd_req are both high in IDLE, the write SHALL win; the read SHALL be taken on a later IDLE cycle in which rd_req is high and wr_ack is 0.
REQ-016 Read accepted with count>0: IDLE->ARM; ARM SHALL assert list_en_read for exactly one cycle, then ARM->STREAM, and the beat counter SHALL load with count.
REQ-017 STREAM: each cycle, list_data_out SHALL be registered onto out_data with out_valid=1 and the beat counter decremented, giving a 1-cycle latency list->out; beat order is last-pushed first.
REQ-018 out_last SHALL be high with the final beat (beat counter==1); STREAM->WAIT_DONE after the final beat.
REQ-019 WAIT_DONE SHALL hold until list_read_done=1, then go to FIN; FIN SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-020 Read accepted with count==0: IDLE->FIN directly; done SHALL pulse with no beats and no list_en_read.
REQ-021 A readout SHALL be non-destructive: count is unchanged.
REQ-022 rd_busy SHALL be high in ARM, STREAM and WAIT_DONE.
REQ-023 rd_req and wr_req SHALL be ignored outside IDLE.
REQ-024 out_valid, out_last and done SHALL be 0 in all cases not specified above.

Reset
REQ-025 RST SHALL force IDLE; count=0, beat counter=0, out_valid=0, out_last=0, out_data=0, done=0, list_en_read=0; wr_ack and list_push SHALL be 0 during RST.
REQ-026 RST asserted mid-readout SHALL abort the readout immediately with no done pulse; the list SHALL share the same RST.

Configuration
REQ-027 Macro LIST_CTRL_OVF_FLAG_EN defined: an output ovf (1 bit) SHALL exist, become sticky 1 on any cycle with wr_req && full in IDLE, and clear only on RST.
REQ-028 LIST_CTRL_OVF_FLAG_EN undefined: no ovf port SHALL exist, and a push request while full SHALL be silently dropped.

Verification
REQ-029 Push 3,1,2 on consecutive cycles, then rd_req -> out_data 2,1,3 with out_valid on 3 consecutive cycles, out_last on the 3rd, then done once; count stays 3.
REQ-030 wr_req and rd_req high together in IDLE with count=0 -> write is acked (count=1); the next rd_req yields 1 beat.
REQ-031 rd_req with count=0 -> done pulses on the next cycle; out_valid and list_en_read stay 0.
REQ-032 MAX_LENGTH=4: 5 pushes -> 4 wr_acks, full=1, 5th not acked; with LIST_CTRL_OVF_FLAG_EN defined, ovf=1.
REQ-033 RST asserted during STREAM -> next cycle state IDLE, count=0, out_valid=0, no done pulse.
REQ-034 wr_req held during STREAM -> wr_ack stays 0 and count is unchanged until FIN completes.

Source files
------------

// File: rtl/list_ctrl.sv
// list_ctrl: push/readout controller for an external LIFO list; readout has 1-cycle list->out latency.
// Optional macro LIST_CTRL_OVF_FLAG_EN adds a sticky ovf output for push attempts while full.
module list_ctrl #(
  parameter int MAX_LENGTH = 256,
  parameter int WIDTH      = 2,
  localparam int CW        = $clog2(MAX_LENGTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic             rd_busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             list_push,
  output logic [WIDTH-1:0] list_data_in,
  output logic             list_en_read,
  input  logic [WIDTH-1:0] list_data_out,
  input  logic             list_read_done
`ifdef LIST_CTRL_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    STREAM    = 3'd2,
    WAIT_DONE = 3'd3,
    FIN       = 3'd4
  } state_t;

  state_t         state;
  logic [CW-1:0]  beat_cnt;

  assign full         = (count == CW'(MAX_LENGTH));
  assign wr_ack       = !RST && (state == IDLE) && wr_req && !full;
  assign list_push    = wr_ack;
  assign list_data_in = wr_data;
  assign rd_busy      = (state == ARM) || (state == STREAM) || (state == WAIT_DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      count        <= '0;
      beat_cnt     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      done         <= 1'b0;
      list_en_read <= 1'b0;
`ifdef LIST_CTRL_OVF_FLAG_EN
      ovf          <= 1'b0;
`endif
    end else begin
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      done         <= 1'b0;
      list_en_read <= 1'b0;
`ifdef LIST_CTRL_OVF_FLAG_EN
      if (state == IDLE && wr_req && full)
        ovf <= 1'b1;
`endif
      case (state)
        IDLE: begin
          // A pending write always wins over a simultaneous read request.
          if (wr_ack) begin
            count <= count + CW'(1);
          end else if (rd_req) begin
            if (count != '0) begin
              state        <= ARM;
              list_en_read <= 1'b1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        ARM: begin
          beat_cnt <= count;
          state    <= STREAM;
        end
        STREAM: begin
          out_data  <= list_data_out;
          out_valid <= 1'b1;
          beat_cnt  <= beat_cnt - CW'(1);
          if (beat_cnt == CW'(1)) begin
            out_last <= 1'b1;
            state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (list_read_done) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_list_ctrl.sv
// Bench for list_ctrl: directed and random push/readout traffic against a queue reference model.
module tb_list_ctrl;
  localparam int ML = 4;
  localparam int W  = 4;
  localparam int CW = $clog2(ML) + 1;

  logic          CLK;
  logic          RST;
  logic          wr_req;
  logic [W-1:0]  wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic          rd_busy;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          done;
  logic [CW-1:0] count;
  logic          full;
  logic          list_push;
  logic [W-1:0]  list_data_in;
  logic          list_en_read;
  logic [W-1:0]  list_data_out;
  logic          list_read_done;
`ifdef LIST_CTRL_OVF_FLAG_EN
  logic          ovf;
`endif

  list_ctrl #(.MAX_LENGTH(ML), .WIDTH(W)) dut (
    .CLK(CLK), .RST(RST),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_busy(rd_busy),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .done(done), .count(count), .full(full),
    .list_push(list_push), .list_data_in(list_data_in),
    .list_en_read(list_en_read), .list_data_out(list_data_out),
    .list_read_done(list_read_done)
`ifdef LIST_CTRL_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] ref_q[$];
  bit exp_ovf = 1'b0;

  // Attached list: stores pushes, then replays newest-first one element per
  // cycle after list_en_read, and reports read_done after a random delay.
  logic [W-1:0] lst[$];
  int rem = 0, idx = 0, dly = 0;
  bit pend = 1'b0;
  initial begin
    list_data_out  = '0;
    list_read_done = 1'b0;
  end
  always @(negedge CLK) begin
    list_read_done = 1'b0;
    if (RST) begin
      lst.delete();
      rem = 0;
      pend = 1'b0;
      list_data_out = '0;
    end else begin
      if (list_push) lst.push_back(list_data_in);
      if (rem > 0) begin
        list_data_out = lst[idx];
        idx--;
        rem--;
        if (rem == 0) begin
          pend = 1'b1;
          dly = $urandom_range(0, 2);
        end
      end else if (pend) begin
        if (dly == 0) begin
          list_read_done = 1'b1;
          pend = 1'b0;
        end else begin
          dly--;
        end
      end
      if (list_en_read) begin
        rem = lst.size();
        idx = rem - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    ref_q.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d);
    bit exp_ack;
    wr_req = 1'b1; wr_data = d; rd_req = 1'b0;
    @(negedge CLK);
    exp_ack = (ref_q.size() < ML);
    chk("push_count", count, ref_q.size());
    chk("push_full", full, ref_q.size() == ML);
    chk("push_wr_ack", wr_ack, exp_ack);
    chk("push_list_push", list_push, exp_ack);
    if (exp_ack) chk("push_list_data", list_data_in, d);
    else exp_ovf = 1'b1;
    if (exp_ack) ref_q.push_back(d);
    @(posedge CLK); #1;
    wr_req = 1'b0;
`ifdef LIST_CTRL_OVF_FLAG_EN
    @(negedge CLK);
    chk("ovf_flag", ovf, exp_ovf);
    @(posedge CLK); #1;
`endif
  endtask

  task automatic do_read(input bit hold_wr);
    int n, en_cnt, en_cyc, done_cyc;
    logic [W-1:0] bd[$];
    bit bl[$];
    int bc[$];
    n = ref_q.size();
    rd_req = 1'b1; wr_req = 1'b0;
    @(negedge CLK);
    chk("rd_accept_wr_ack", wr_ack, 0);
    chk("rd_accept_busy", rd_busy, 0);
    @(posedge CLK); #1;
    rd_req = 1'b0; wr_req = hold_wr; wr_data = W'($urandom);
    en_cnt = 0; en_cyc = -1; done_cyc = -1;
    for (int c = 0; c < 60 && done_cyc < 0; c++) begin
      @(negedge CLK);
      if (list_en_read) begin en_cnt++; en_cyc = c; end
      if (out_valid) begin
        bd.push_back(out_data); bl.push_back(out_last); bc.push_back(c);
        chk("beat_busy", rd_busy, 1);
      end
      if (hold_wr) begin
        chk("hold_wr_ack", wr_ack, 0);
        chk("hold_count", count, n);
      end
      if (done) done_cyc = c;
      @(posedge CLK); #1;
    end
    wr_req = 1'b0;
    chk("read_done_seen", done_cyc >= 0, 1);
    chk("beat_count", bd.size(), n);
    for (int i = 0; i < bd.size() && i < n; i++) begin
      chk("beat_data", bd[i], ref_q[n-1-i]);
      chk("beat_last", bl[i], i == n - 1);
      chk("beat_cycle", bc[i], 2 + i);
    end
    chk("en_read_pulses", en_cnt, (n > 0) ? 1 : 0);
    if (n > 0) begin
      chk("en_read_cycle", en_cyc, 0);
      chk("done_after_beats", done_cyc > n + 1, 1);
    end else begin
      chk("empty_done_cycle", done_cyc, 0);
    end
    @(negedge CLK);
    chk("done_single", done, 0);
    chk("read_count_kept", count, n);
    chk("read_busy_clear", rd_busy, 0);
    @(posedge CLK); #1;
  endtask

  initial begin
    // Reset values, with a write request pending that must not be acked.
    RST = 1'b1; wr_req = 1'b1; wr_data = 4'h5; rd_req = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_en_read", list_en_read, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_list_push", list_push, 0);
    chk("rst_busy", rd_busy, 0);
    chk("rst_full", full, 0);
`ifdef LIST_CTRL_OVF_FLAG_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(posedge CLK); #1;
    RST = 1'b0; wr_req = 1'b0;

    // Push 3,1,2 then read back newest-first.
    push(4'd3); push(4'd1); push(4'd2);
    do_read(1'b0);

    // Simultaneous write and read on an empty list: write wins, then 1 beat.
    do_reset();
    wr_req = 1'b1; rd_req = 1'b1; wr_data = 4'hA;
    @(negedge CLK);
    chk("arb_wr_ack", wr_ack, 1);
    ref_q.push_back(4'hA);
    @(posedge CLK); #1;
    wr_req = 1'b0;
    do_read(1'b0);

    // Readout of an empty list.
    do_reset();
    do_read(1'b0);

    // Overflow: five pushes into a four-deep list.
    for (int i = 0; i < 5; i++) push(W'($urandom));
    @(negedge CLK);
    chk("full_after_fill", full, 1);
    chk("count_after_fill", count, ML);
    @(posedge CLK); #1;

    // Write request held across a readout.
    do_read(1'b1);

    // Random traffic.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0, m = $urandom_range(1, 3); k < m; k++) push(W'($urandom));
      end else begin
        do_read(1'($urandom_range(0, 1)));
      end
    end

    // Reset asserted while streaming.
    do_reset();
    push(4'h7); push(4'h8); push(4'h9);
    rd_req = 1'b1;
    @(posedge CLK); #1;
    rd_req = 1'b0;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge CLK);
        seen = out_valid;
        @(posedge CLK); #1;
      end
      chk("stream_started", seen, 1);
    end
    RST = 1'b1; wr_req = 1'b1;
    @(negedge CLK);
    chk("midrst_wr_ack", wr_ack, 0);
    chk("midrst_list_push", list_push, 0);
    @(posedge CLK); #1;
    RST = 1'b0; wr_req = 1'b0;
    ref_q.delete();
    exp_ovf = 1'b0;
    @(negedge CLK);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_busy", rd_busy, 0);
    chk("midrst_en_read", list_en_read, 0);
    @(posedge CLK); #1;
    begin
      bit any_done = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge CLK);
        if (done) any_done = 1'b1;
        @(posedge CLK); #1;
      end
      chk("midrst_no_done", any_done, 0);
    end
    push(4'hC);
    do_read(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
